// File: rtl/cosx_pkg.sv
// cosx_pkg: shared FSM state encoding, default sizes and the round-robin distance helper.
package cosx_pkg;

    localparam int COSX_W    = 16;
    localparam int COSX_NREQ = 4;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_BUSY = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } cosx_state_e;

    // Position of requester i in the search order that starts at owner+1 (0 = searched first).
    function automatic int rr_dist(input int i, input int owner, input int n);
        return (i + n - 1 - owner) % n;
    endfunction

endpackage

// File: rtl/cosx_rr_pick.sv
// cosx_rr_pick: combinational round-robin picker. The search starts just after
// last_owner and wraps; valid is low when no request is pending.
module cosx_rr_pick
    import cosx_pkg::*;
#(
    parameter int N_REQ = COSX_NREQ,
    parameter int IW    = $clog2(COSX_NREQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last_owner,
    output logic             valid,
    output logic [IW-1:0]    winner
);

    int best;

    // Keep the pending requester that comes earliest in the rotated search order.
    always_comb begin
        valid  = 1'b0;
        winner = '0;
        best   = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            if (req[i] && (rr_dist(i, int'(last_owner), N_REQ) < best)) begin
                best   = rr_dist(i, int'(last_owner), N_REQ);
                valid  = 1'b1;
                winner = IW'(i);
            end
        end
    end

endmodule

// File: rtl/cosx_arbiter.sv
// cosx_arbiter: shares one cosine accelerator among N_REQ requesters with round-robin
// arbitration. Optional watchdog: define COSX_ARB_TIMEOUT_EN to add the wait-state
// timeout and the err output.
module cosx_arbiter
    import cosx_pkg::*;
#(
    parameter int N_REQ   = COSX_NREQ,
    parameter int W       = COSX_W,
    parameter int TIMEOUT = 64
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req,
    input  logic [N_REQ*W-1:0] req_x,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   ack,
    output logic [W-1:0]       rsp_data,
    output logic               busy,
    output logic               acc_start,
    output logic [W-1:0]       acc_x,
    input  logic               acc_done,
    input  logic [W-1:0]       acc_r
`ifdef COSX_ARB_TIMEOUT_EN
    ,
    output logic               err
`endif
);

    // Handshake: a requester raises req[i] with its operand on req_x and holds both until
    // it sees ack[i] (one cycle, rsp_data valid in that cycle). The operand is captured
    // only on the IDLE->ISSUE edge. Toward the accelerator, acc_start is a one-cycle
    // command; acc_done must first drop (work accepted) and then rise (result on acc_r).

    localparam int IW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
        $error("cosx_arbiter: N_REQ must be in 2..8");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("cosx_arbiter: TIMEOUT must be at least 1");
    end

    cosx_state_e   state;
    cosx_state_e   state_n;
    logic [IW-1:0] last_owner;
    logic [IW-1:0] pick_winner;
    logic          pick_valid;
    logic          in_wait;
    logic          time_up;
    logic [W-1:0]  x_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign x_arr[g] = req_x[g*W +: W];
    end

    cosx_rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req        (req),
        .last_owner (last_owner),
        .valid      (pick_valid),
        .winner     (pick_winner)
    );

    assign in_wait = (state == WAIT_BUSY) || (state == WAIT_DONE);

`ifdef COSX_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] to_cnt;
    logic          to_hit;

    // Watchdog counter runs only while waiting on the accelerator; to_hit marks a forced RESP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt <= '0;
            to_hit <= 1'b0;
        end else begin
            to_cnt <= in_wait ? to_cnt + TW'(1) : '0;
            to_hit <= time_up;
        end
    end

    assign time_up = in_wait && (to_cnt == TW'(TIMEOUT - 1));
    assign err     = to_hit;
`else
    assign time_up = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic; done only counts as completion after it has been seen low.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:      if (pick_valid) state_n = ISSUE;
            ISSUE:     state_n = WAIT_BUSY;
            WAIT_BUSY: if (!acc_done) state_n = WAIT_DONE;
            WAIT_DONE: if (acc_done) state_n = RESP;
            RESP:      state_n = IDLE;
            default:   state_n = IDLE;
        endcase
        if (time_up) state_n = RESP;
    end

    // Outputs decoded from the current state.
    always_comb begin
        busy      = (state != IDLE);
        acc_start = (state == ISSUE);
        ack       = (state == RESP) ? gnt : '0;
    end

    // Grant, operand and result registers; the grant is frozen from ISSUE through RESP.
    always_ff @(posedge clk) begin
        if (!rst) begin
            gnt        <= '0;
            acc_x      <= '0;
            rsp_data   <= '0;
            last_owner <= IW'(N_REQ - 1);
        end else begin
            if (state == IDLE && pick_valid) begin
                gnt        <= N_REQ'(1) << pick_winner;
                acc_x      <= x_arr[pick_winner];
                last_owner <= pick_winner;
            end else if (state == RESP) begin
                gnt <= '0;
            end
            if (time_up) begin
                rsp_data <= '0;
            end else if (state == WAIT_DONE && acc_done) begin
                rsp_data <= acc_r;
            end
        end
    end

endmodule

// File: tb/tb_cosx_arbiter.sv
// tb_cosx_arbiter: bench for cosx_arbiter with a behavioural accelerator and a
// transaction-level round-robin reference model. Follows COSX_ARB_TIMEOUT_EN.
module tb_cosx_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int TO = 64;

    // ---------------- clock / reset / DUT ----------------
    logic           clk   = 1'b0;
    logic           rst   = 1'b0;
    logic [N-1:0]   req   = '0;
    logic [N*W-1:0] req_x = '0;
    logic [N-1:0]   gnt;
    logic [N-1:0]   ack;
    logic [W-1:0]   rsp_data;
    logic           busy;
    logic           acc_start;
    logic [W-1:0]   acc_x;
    logic           acc_done;
    logic [W-1:0]   acc_r;
`ifdef COSX_ARB_TIMEOUT_EN
    logic           err;
`endif

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    cosx_arbiter #(
        .N_REQ   (N),
        .W       (W),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_x     (req_x),
        .gnt       (gnt),
        .ack       (ack),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .acc_start (acc_start),
        .acc_x     (acc_x),
        .acc_done  (acc_done),
        .acc_r     (acc_r)
`ifdef COSX_ARB_TIMEOUT_EN
        ,
        .err       (err)
`endif
    );

    // ---------------- accelerator model ----------------
    // After a start, done stays high for acc_pre cycles, then low for acc_len cycles.
    int           acc_pre  = 1;
    int           acc_len  = 10;
    bit           hang     = 1'b0;
    int           pre_cnt  = 0;
    int           busy_cnt = 0;
    logic [W-1:0] acc_op   = '0;

    function automatic logic [W-1:0] cos_model(input logic [W-1:0] x);
        return {x[7:0], x[15:8]} ^ 16'hC05A;
    endfunction

    always @(posedge clk) begin
        if (acc_start) begin
            pre_cnt  <= acc_pre;
            busy_cnt <= acc_len;
            acc_op   <= acc_x;
        end else if (pre_cnt > 0) begin
            pre_cnt <= pre_cnt - 1;
        end else if (busy_cnt > 0 && !hang) begin
            busy_cnt <= busy_cnt - 1;
        end
    end

    assign acc_done = (busy_cnt == 0) || (pre_cnt > 0);
    assign acc_r    = cos_model(acc_op);

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    int           exp_idx_q[$];
    int           exp_cyc_q[$];
    int           start_q[$];
    logic [N-1:0] gnt_q[$];
    int           err_q[$];
    int           first_gnt;
    bit           gnt_seen    = 1'b0;
    bit           drop_on_ack = 1'b1;
    int           stop_after  = -1;
    int           acks_seen   = 0;
    int           t0          = 0;
    int           model_last  = N - 1;
    logic [W-1:0] xs [N];
    int           n_checks    = 0;
    int           n_errors    = 0;

    // ---------------- driver tasks ----------------
    task automatic set_x();
        for (int i = 0; i < N; i++) req_x[i*W +: W] = xs[i];
    endtask

    task automatic clear_obs();
        exp_q.delete();
        exp_idx_q.delete();
        exp_cyc_q.delete();
        start_q.delete();
        gnt_q.delete();
        err_q.delete();
        first_gnt  = -1;
        acks_seen  = 0;
        stop_after = -1;
    endtask

    // One clock: observe outputs at the falling edge, score acks, then let requesters react.
    task automatic tick();
        logic [W-1:0] e_d;
        logic [N-1:0] e_v;
        int           e_i;
        int           e_c;
        @(negedge clk);
        if (acc_start === 1'b1) start_q.push_back(cyc - t0);
        if (gnt !== '0 && !gnt_seen) begin
            gnt_q.push_back(gnt);
            if (first_gnt < 0) first_gnt = cyc - t0;
        end
        gnt_seen = (gnt !== '0);
`ifdef COSX_ARB_TIMEOUT_EN
        if (err === 1'b1) err_q.push_back(cyc - t0);
`endif
        if (ack !== '0) begin
            n_checks++;
            acks_seen++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL sb_unexpected_ack: got ack=%b rsp=%h at cycle %0d, none required",
                         ack, rsp_data, cyc - t0);
            end else begin
                e_d = exp_q.pop_front();
                e_i = exp_idx_q.pop_front();
                e_c = exp_cyc_q.pop_front();
                e_v = '0;
                e_v[e_i] = 1'b1;
                if (ack !== e_v || rsp_data !== e_d || (cyc - t0) != e_c) begin
                    n_errors++;
                    $display("FAIL sb_ack: got ack=%b rsp=%h cycle=%0d, required ack=%b rsp=%h cycle=%0d",
                             ack, rsp_data, cyc - t0, e_v, e_d, e_c);
                end
            end
            if (drop_on_ack) req = req & ~ack;
            if (acks_seen == stop_after) req = '0;
        end
    endtask

    // Reference model: serve pending requesters round-robin from model_last+1; each
    // transaction takes 3+d+b cycles from its IDLE sample to ack, plus one IDLE cycle.
    task automatic predict(input logic [N-1:0] mask, input bit hold, input int n_acks,
                           input int d, input int b);
        logic [N-1:0] pend;
        int t;
        int s;
        int w;
        int i;
        pend = mask;
        t    = 0;
        s    = 3 + d + b;
        for (int n = 0; n < n_acks; n++) begin
            w = -1;
            for (int k = 1; k <= N; k++) begin
                i = (model_last + k) % N;
                if (w < 0 && pend[i]) w = i;
            end
            if (w < 0) break;
            exp_idx_q.push_back(w);
            exp_q.push_back(cos_model(xs[w]));
            exp_cyc_q.push_back(t + s);
            if (!hold) pend[w] = 1'b0;
            model_last = w;
            t = t + s + 1;
        end
    endtask

    // Raise mask at cycle 0; requesters drop on their ack (or all drop after n_acks when held).
    task automatic run_traffic(input logic [N-1:0] mask, input bit hold, input int n_acks,
                               input int d, input int b);
        int budget;
        clear_obs();
        acc_pre = d;
        acc_len = b;
        predict(mask, hold, n_acks, d, b);
        stop_after  = hold ? n_acks : -1;
        drop_on_ack = !hold;
        budget      = n_acks * (4 + d + b) + 8;
        t0  = cyc;
        req = mask;
        for (int k = 0; k < budget; k++) tick();
        req = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_obs();
        t0  = cyc;
        rst = 1'b0;
        req = 4'b1111;
        tick();
        tick();
        n_checks++; if (gnt !== '0)       begin n_errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
        n_checks++; if (ack !== '0)       begin n_errors++; $display("FAIL reset_ack: got %b want 0000", ack); end
        n_checks++; if (rsp_data !== '0)  begin n_errors++; $display("FAIL reset_rsp: got %h want 0000", rsp_data); end
        n_checks++; if (acc_start !== 1'b0) begin n_errors++; $display("FAIL reset_start: got %b want 0", acc_start); end
        n_checks++; if (acc_x !== '0)     begin n_errors++; $display("FAIL reset_acc_x: got %h want 0000", acc_x); end
        n_checks++; if (busy !== 1'b0)    begin n_errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        req = '0;
        rst = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0 || gnt !== '0) begin
            n_errors++; $display("FAIL reset_idle_noreq: got busy=%b gnt=%b want 0/0000", busy, gnt);
        end
        model_last = N - 1;
    endtask

    task automatic test_contention();
        for (int i = 0; i < N; i++) xs[i] = W'(16'h1111 * (i + 1));
        set_x();
        run_traffic(4'b1111, 1'b1, 5, 1, 2);
        n_checks++; if (exp_q.size() != 0) begin
            n_errors++; $display("FAIL contention_acks: got %0d missing acks want 0", exp_q.size());
        end
        n_checks++; if (gnt_q.size() != 5 || gnt_q[0] !== 4'b0001 || gnt_q[1] !== 4'b0010 ||
                        gnt_q[2] !== 4'b0100 || gnt_q[3] !== 4'b1000 || gnt_q[4] !== 4'b0001) begin
            n_errors++; $display("FAIL contention_order: got %p want 0001,0010,0100,1000,0001", gnt_q);
        end
    endtask

    task automatic test_single();
        xs[0] = 16'h0100;
        set_x();
        run_traffic(4'b0001, 1'b0, 1, 1, 10);
        n_checks++; if (first_gnt != 1 || gnt_q.size() != 1 || gnt_q[0] !== 4'b0001) begin
            n_errors++; $display("FAIL single_gnt: got cycle %0d count %0d want 0001 at cycle 1", first_gnt, gnt_q.size());
        end
        n_checks++; if (start_q.size() != 1 || start_q[0] != 1) begin
            n_errors++; $display("FAIL single_start: got %p want one pulse at cycle 1", start_q);
        end
        n_checks++; if (exp_q.size() != 0) begin
            n_errors++; $display("FAIL single_ack: got %0d missing acks want 0", exp_q.size());
        end
    endtask

    task automatic test_early_done();
        xs[3] = 16'hBEEF;
        set_x();
        run_traffic(4'b1000, 1'b0, 1, 2, 4);
        n_checks++; if (exp_q.size() != 0 || start_q.size() != 1) begin
            n_errors++; $display("FAIL early_done: got %0d missing acks, %0d starts want 0, 1", exp_q.size(), start_q.size());
        end
    endtask

    task automatic test_operand_change();
        clear_obs();
        acc_pre = 1;
        acc_len = 10;
        xs[2]   = 16'h0040;
        set_x();
        predict(4'b0100, 1'b0, 1, 1, 10);
        drop_on_ack = 1'b1;
        t0  = cyc;
        req = 4'b0100;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 2) begin
                xs[2] = 16'h7FFF;
                set_x();
            end
            if (k == 5) begin
                n_checks++; if (acc_x !== 16'h0040 || gnt !== 4'b0100) begin
                    n_errors++; $display("FAIL operand_hold: got acc_x=%h gnt=%b want 0040/0100", acc_x, gnt);
                end
            end
        end
        n_checks++; if (exp_q.size() != 0 || acc_x !== 16'h0040) begin
            n_errors++; $display("FAIL operand_after: got %0d missing acks acc_x=%h want 0 and 0040", exp_q.size(), acc_x);
        end
    endtask

    task automatic test_reset_mid();
        clear_obs();
        acc_pre = 1;
        acc_len = 10;
        drop_on_ack = 1'b1;
        t0  = cyc;
        req = 4'b0001;
        repeat (6) tick();
        n_checks++; if (busy !== 1'b1 || gnt !== 4'b0001) begin
            n_errors++; $display("FAIL rmid_pre: got busy=%b gnt=%b want 1/0001", busy, gnt);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        req = '0;
        n_checks++; if (busy !== 1'b0 || gnt !== '0 || ack !== '0) begin
            n_errors++; $display("FAIL rmid_abort: got busy=%b gnt=%b ack=%b want 0/0000/0000", busy, gnt, ack);
        end
        model_last = N - 1;
        run_traffic(4'b0011, 1'b0, 2, 1, 3);
        n_checks++; if (exp_q.size() != 0 || gnt_q.size() < 1 || gnt_q[0] !== 4'b0001) begin
            n_errors++; $display("FAIL rmid_restart: got first gnt %p missing %0d want 0001 first", gnt_q, exp_q.size());
        end
        run_traffic(4'b0010, 1'b0, 1, 1, 3);
        n_checks++; if (exp_q.size() != 0 || gnt_q.size() != 1 || gnt_q[0] !== 4'b0010) begin
            n_errors++; $display("FAIL rmid_req1: got gnt %p missing %0d want 0010", gnt_q, exp_q.size());
        end
    endtask

    task automatic test_random();
        logic [N-1:0] mask;
        bit hold;
        int nack;
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < N; i++) xs[i] = W'($urandom);
            set_x();
            mask = N'($urandom_range(1, 15));
            hold = 1'($urandom_range(0, 1));
            nack = hold ? $urandom_range(1, 6) : N;
            run_traffic(mask, hold, nack, $urandom_range(0, 2), $urandom_range(1, 6));
            n_checks++; if (exp_q.size() != 0) begin
                n_errors++; $display("FAIL random_round%0d: got %0d missing acks want 0 (mask %b)", r, exp_q.size(), mask);
            end
        end
    endtask

    task automatic test_timeout();
        clear_obs();
        acc_pre = 1;
        acc_len = 10;
        hang    = 1'b1;
        drop_on_ack = 1'b1;
`ifdef COSX_ARB_TIMEOUT_EN
        exp_q.push_back('0);
        exp_idx_q.push_back(0);
        exp_cyc_q.push_back(2 + TO);
        t0  = cyc;
        req = 4'b0001;
        repeat (TO + 16) tick();
        n_checks++; if (exp_q.size() != 0) begin
            n_errors++; $display("FAIL timeout_ack: got %0d missing acks want 0", exp_q.size());
        end
        n_checks++; if (err_q.size() != 1 || err_q[0] != 2 + TO) begin
            n_errors++; $display("FAIL timeout_err: got %p want one pulse at cycle %0d", err_q, 2 + TO);
        end
`else
        t0  = cyc;
        req = 4'b0001;
        repeat (1000) tick();
        n_checks++; if (busy !== 1'b1 || gnt !== 4'b0001 || ack !== '0) begin
            n_errors++; $display("FAIL nowatchdog_wait: got busy=%b gnt=%b ack=%b want 1/0001/0000", busy, gnt, ack);
        end
        n_checks++; if (start_q.size() != 1) begin
            n_errors++; $display("FAIL nowatchdog_start: got %0d starts want 1", start_q.size());
        end
`endif
        hang = 1'b0;
        req  = '0;
        rst  = 1'b0;
        tick();
        rst  = 1'b1;
        tick();
        model_last = N - 1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        for (int i = 0; i < N; i++) xs[i] = '0;
        test_reset();
        test_contention();
        test_single();
        test_early_done();
        test_operand_change();
        test_reset_mid();
        test_random();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 20000 cycles");
        $fatal(1, "watchdog expired");
    end

endmodule
